multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/control_pkg.sv | 78 +++++++
 rtl/alu_decoder.sv | 26 ++
 rtl/multicycle_control_unit.sv | 170 +++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - states, opcodes, ALU codes and mux-select codes for the multicycle controller
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JALR     = 4'd10,
    S_JAL      = 4'd11,
    S_LUI      = 4'd12,
    S_HALT     = 4'd13
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;

  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMM       = 2'b11;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_RESULT = 1'b1;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] SIZE_WORD = 3'b010;

  // Flags come from SUB(A, B): cout=1 means no borrow, i.e. A >= B unsigned.
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic c, input logic ovf, input logic sgn);
    case (f3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return sgn ^ ovf;
      3'b101:  return !(sgn ^ ovf);
      3'b110:  return !c;
      3'b111:  return c;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps funct3/funct7 to an ALUControl code for R- and I-type operations
module alu_decoder
  import control_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_funct7,
  input  logic       i_is_rtype,
  output logic [3:0] o_alu_control
);

  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_funct3)
      // funct7 on immediate adds is just an immediate bit, so only R-type subtracts
      3'b000:  o_alu_control = (i_is_rtype && i_funct7) ? ALU_SUB : ALU_ADD;
      3'b001:  o_alu_control = ALU_SLL;
      3'b010:  o_alu_control = ALU_SLT;
      3'b011:  o_alu_control = ALU_SLTU;
      3'b100:  o_alu_control = ALU_XOR;
      3'b101:  o_alu_control = i_funct7 ? ALU_SRA : ALU_SRL;
      3'b110:  o_alu_control = ALU_OR;
      default: o_alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32 control FSM; CTRL_FULL_BRANCH_EN enables all six branches
// Without CTRL_FULL_BRANCH_EN only BEQ/BNE decode; other branch funct3 values halt.
module multicycle_control_unit
  import control_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] OP,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       cout,
  input  logic       overflow,
  input  logic       sign,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic [3:0] ALUControl,
  output logic       AdrSrc,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic [2:0] size,
  output logic [3:0] state,
  output logic       halted
);

  state_e     r_state;
  logic [3:0] w_dec_ctrl;
  logic       w_use_dec;
  logic       w_sub;
  logic       w_pc_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_ir_write;

  alu_decoder u_alu_decoder (
    .i_funct3      (funct3),
    .i_funct7      (funct7),
    .i_is_rtype    (r_state == S_EXECR),
    .o_alu_control (w_dec_ctrl)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (OP)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_RTYPE:          r_state <= S_EXECR;
            OP_ITYPE:          r_state <= S_EXECI;
`ifdef CTRL_FULL_BRANCH_EN
            OP_BRANCH:         r_state <= S_BRANCH;
`else
            OP_BRANCH:         r_state <= (funct3[2:1] == 2'b00) ? S_BRANCH : S_HALT;
`endif
            OP_JAL:            r_state <= S_JAL;
            OP_JALR:           r_state <= S_JALR;
            OP_LUI:            r_state <= S_LUI;
            default:           r_state <= S_HALT;
          endcase
        end
        S_MEMADR:   r_state <= (OP == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: r_state <= S_FETCH;
        S_EXECR:    r_state <= S_ALUWB;
        S_EXECI:    r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_BRANCH:   r_state <= S_FETCH;
        // JALR computes the target into ALUOut, then reuses JAL to link and jump
        S_JALR:     r_state <= S_JAL;
        S_JAL:      r_state <= S_ALUWB;
        S_LUI:      r_state <= S_FETCH;
        default:    r_state <= S_HALT;
      endcase
    end
  end

  always_comb begin
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_WD;
    ImmSrc      = IMM_I;
    ResultSrc   = RES_ALUOUT;
    AdrSrc      = ADR_PC;
    size        = SIZE_WORD;
    w_use_dec   = 1'b0;
    w_sub       = 1'b0;
    w_pc_write  = 1'b0;
    w_mem_write = 1'b0;
    w_reg_write = 1'b0;
    w_ir_write  = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        w_ir_write = 1'b1;
        w_pc_write = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (OP == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (OP == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        AdrSrc = ADR_RESULT;
        size   = funct3;
      end
      S_MEMWB: begin
        ResultSrc   = RES_DATA;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = ADR_RESULT;
        size        = funct3;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA   = SRCA_A;
        w_use_dec = 1'b1;
      end
      S_EXECI: begin
        ALUSrcA   = SRCA_A;
        ALUSrcB   = SRCB_IMM;
        w_use_dec = 1'b1;
      end
      S_ALUWB:  w_reg_write = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = SRCA_A;
        w_sub      = 1'b1;
        w_pc_write = branch_taken(funct3, Zero, cout, overflow, sign);
      end
      S_JALR: begin
        ALUSrcA = SRCA_A;
        ALUSrcB = SRCB_IMM;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        w_pc_write = 1'b1;
      end
      S_LUI: begin
        ResultSrc   = RES_IMM;
        w_reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign ALUControl = w_use_dec ? w_dec_ctrl : (w_sub ? ALU_SUB : ALU_ADD);

  // Reset must silence every enable immediately, not one cycle later
  assign PCWrite  = RESET & w_pc_write;
  assign MemWrite = RESET & w_mem_write;
  assign RegWrite = RESET & w_reg_write;
  assign IRWrite  = RESET & w_ir_write;
  assign halted   = RESET & (r_state == S_HALT);
  assign state    = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for the multicycle control unit
module tb_multicycle_control_unit;
  import control_pkg::*;

  logic       CLK;
  logic       RESET;
  logic [6:0] OP;
  logic [2:0] funct3;
  logic       funct7, Zero, cout, overflow, sign;
  logic [1:0] ALUSrcA, ALUSrcB, ImmSrc, ResultSrc;
  logic [3:0] ALUControl;
  logic       AdrSrc, PCWrite, MemWrite, RegWrite, IRWrite;
  logic [2:0] size;
  logic [3:0] state;
  logic       halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [24:0] exp_q[$];
  string       name_q[$];

  multicycle_control_unit dut (
    .CLK(CLK), .RESET(RESET), .OP(OP), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .cout(cout), .overflow(overflow), .sign(sign),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .AdrSrc(AdrSrc), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .size(size), .state(state), .halted(halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Packed layout: state, halted, {PCWrite,MemWrite,RegWrite,IRWrite}, AdrSrc, SrcA, SrcB, Imm, Res, ALU, size
  function automatic logic [24:0] ex(input logic [3:0] st, input logic [3:0] we, input logic adr,
                                     input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] imm,
                                     input logic [1:0] res, input logic [3:0] alu, input logic [2:0] sz,
                                     input logic h);
    return {st, h, we, adr, sa, sb, imm, res, alu, sz};
  endfunction

  function automatic logic [24:0] e_fetch(input logic en);
    return ex(S_FETCH, en ? 4'b1001 : 4'b0000, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 4'b0000, 3'b010, 1'b0);
  endfunction
  function automatic logic [24:0] e_decode(input logic [1:0] imm);
    return ex(S_DECODE, 4'b0000, 1'b0, 2'b01, 2'b01, imm, 2'b00, 4'b0000, 3'b010, 1'b0);
  endfunction
  function automatic logic [24:0] e_aluwb();
    return ex(S_ALUWB, 4'b0010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b010, 1'b0);
  endfunction
  function automatic logic [24:0] e_memadr(input logic [1:0] imm);
    return ex(S_MEMADR, 4'b0000, 1'b0, 2'b10, 2'b01, imm, 2'b00, 4'b0000, 3'b010, 1'b0);
  endfunction
  function automatic logic [24:0] e_branch(input logic taken);
    return ex(S_BRANCH, {taken, 3'b000}, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0001, 3'b010, 1'b0);
  endfunction
  function automatic logic [24:0] e_halt(input logic h);
    return ex(S_HALT, 4'b0000, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b010, h);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input string nm, input logic [24:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic z, input logic c, input logic ov, input logic sg);
    OP = op; funct3 = f3; funct7 = f7; Zero = z; cout = c; overflow = ov; sign = sg;
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      logic [24:0] e;
      logic [24:0] a;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {state, halted, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
            ImmSrc, ResultSrc, ALUControl, size};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got st=%0d h=%b we=%b adr=%b sa=%b sb=%b imm=%b res=%b alu=%b sz=%b, expected %b",
                 nm, a[24:21], a[20], a[19:16], a[15], a[14:13], a[12:11], a[10:9], a[8:7],
                 a[6:3], a[2:0], e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1);
  end

  initial begin
    RESET = 1'b0;
    set_in(7'b0, 3'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); push("rst0", e_fetch(1'b0));
    tick(); push("rst1", e_fetch(1'b0));

    // R-type SUB
    tick(); RESET = 1'b1; set_in(7'b0110011, 3'b000, 1'b1, 0, 0, 0, 0); push("sub_fetch", e_fetch(1'b1));
    tick(); push("sub_decode", e_decode(2'b10));
    tick(); push("sub_execr", ex(S_EXECR, 4'b0000, 0, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0001, 3'b010, 0));
    tick(); push("sub_aluwb", e_aluwb());

    // LW
    tick(); set_in(7'b0000011, 3'b010, 1'b0, 0, 0, 0, 0); push("lw_fetch", e_fetch(1'b1));
    tick(); push("lw_decode", e_decode(2'b10));
    tick(); push("lw_memadr", e_memadr(2'b00));
    tick(); push("lw_memread", ex(S_MEMREAD, 4'b0000, 1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b010, 0));
    tick(); push("lw_memwb", ex(S_MEMWB, 4'b0010, 0, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 3'b010, 0));

    // SB: size follows funct3
    tick(); set_in(7'b0100011, 3'b000, 1'b0, 0, 0, 0, 0); push("sb_fetch", e_fetch(1'b1));
    tick(); push("sb_decode", e_decode(2'b10));
    tick(); push("sb_memadr", e_memadr(2'b01));
    tick(); push("sb_memwrite", ex(S_MEMWRITE, 4'b0100, 1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b000, 0));

    // ADDI with bit30 set stays ADD
    tick(); set_in(7'b0010011, 3'b000, 1'b1, 0, 0, 0, 0); push("addi_fetch", e_fetch(1'b1));
    tick(); push("addi_decode", e_decode(2'b10));
    tick(); push("addi_execi", ex(S_EXECI, 4'b0000, 0, 2'b10, 2'b01, 2'b00, 2'b00, 4'b0000, 3'b010, 0));
    tick(); push("addi_aluwb", e_aluwb());

    // SRAI
    tick(); set_in(7'b0010011, 3'b101, 1'b1, 0, 0, 0, 0); push("srai_fetch", e_fetch(1'b1));
    tick(); push("srai_decode", e_decode(2'b10));
    tick(); push("srai_execi", ex(S_EXECI, 4'b0000, 0, 2'b10, 2'b01, 2'b00, 2'b00, 4'b0111, 3'b010, 0));
    tick(); push("srai_aluwb", e_aluwb());

    // SRL and SLTU R-type
    tick(); set_in(7'b0110011, 3'b101, 1'b0, 0, 0, 0, 0); push("srl_fetch", e_fetch(1'b1));
    tick(); push("srl_decode", e_decode(2'b10));
    tick(); push("srl_execr", ex(S_EXECR, 4'b0000, 0, 2'b10, 2'b00, 2'b00, 2'b00, 4'b0110, 3'b010, 0));
    tick(); push("srl_aluwb", e_aluwb());
    tick(); set_in(7'b0110011, 3'b011, 1'b0, 0, 0, 0, 0); push("sltu_fetch", e_fetch(1'b1));
    tick(); push("sltu_decode", e_decode(2'b10));
    tick(); push("sltu_execr", ex(S_EXECR, 4'b0000, 0, 2'b10, 2'b00, 2'b00, 2'b00, 4'b1001, 3'b010, 0));
    tick(); push("sltu_aluwb", e_aluwb());

    // BEQ taken, BNE not taken
    tick(); set_in(7'b1100011, 3'b000, 1'b0, 1, 0, 0, 0); push("beq_fetch", e_fetch(1'b1));
    tick(); push("beq_decode", e_decode(2'b10));
    tick(); push("beq_branch", e_branch(1'b1));
    tick(); set_in(7'b1100011, 3'b001, 1'b0, 1, 0, 0, 0); push("bne_fetch", e_fetch(1'b1));
    tick(); push("bne_decode", e_decode(2'b10));
    tick(); push("bne_branch", e_branch(1'b0));

    // JALR
    tick(); set_in(7'b1100111, 3'b000, 1'b0, 0, 0, 0, 0); push("jalr_fetch", e_fetch(1'b1));
    tick(); push("jalr_decode", e_decode(2'b10));
    tick(); push("jalr_jalr", ex(S_JALR, 4'b0000, 0, 2'b10, 2'b01, 2'b00, 2'b00, 4'b0000, 3'b010, 0));
    tick(); push("jalr_jal", ex(S_JAL, 4'b1000, 0, 2'b01, 2'b10, 2'b00, 2'b00, 4'b0000, 3'b010, 0));
    tick(); push("jalr_aluwb", e_aluwb());

    // JAL
    tick(); set_in(7'b1101111, 3'b000, 1'b0, 0, 0, 0, 0); push("jal_fetch", e_fetch(1'b1));
    tick(); push("jal_decode", e_decode(2'b11));
    tick(); push("jal_jal", ex(S_JAL, 4'b1000, 0, 2'b01, 2'b10, 2'b00, 2'b00, 4'b0000, 3'b010, 0));
    tick(); push("jal_aluwb", e_aluwb());

    // LUI
    tick(); set_in(7'b0110111, 3'b000, 1'b0, 0, 0, 0, 0); push("lui_fetch", e_fetch(1'b1));
    tick(); push("lui_decode", e_decode(2'b10));
    tick(); push("lui_lui", ex(S_LUI, 4'b0010, 0, 2'b00, 2'b00, 2'b00, 2'b11, 4'b0000, 3'b010, 0));

    // BLT
    tick(); set_in(7'b1100011, 3'b100, 1'b0, 0, 0, 0, 1); push("blt_fetch", e_fetch(1'b1));
    tick(); push("blt_decode", e_decode(2'b10));
`ifdef CTRL_FULL_BRANCH_EN
    tick(); push("blt_taken", e_branch(1'b1));
    tick(); set_in(7'b1100011, 3'b100, 1'b0, 0, 0, 1, 1); push("blt2_fetch", e_fetch(1'b1));
    tick(); push("blt2_decode", e_decode(2'b10));
    tick(); push("blt2_not_taken", e_branch(1'b0));
`else
    tick(); push("blt_halt0", e_halt(1'b1));
    tick(); push("blt_halt1", e_halt(1'b1));
    tick(); RESET = 1'b0; push("blt_halt_rst", e_halt(1'b0));
    tick(); push("blt_rst_fetch", e_fetch(1'b0));
`endif

    // Illegal opcode -> HALT held, then reset
    tick(); RESET = 1'b1; set_in(7'b0000000, 3'b000, 1'b0, 0, 0, 0, 0); push("ill_fetch", e_fetch(1'b1));
    tick(); push("ill_decode", e_decode(2'b10));
    for (int i = 0; i < 10; i++) begin
      tick(); push($sformatf("halt_hold%0d", i), e_halt(1'b1));
    end
    tick(); RESET = 1'b0; push("halt_rst", e_halt(1'b0));

    // Reset during MEMWRITE
    tick(); RESET = 1'b1; set_in(7'b0100011, 3'b010, 1'b0, 0, 0, 0, 0); push("rst_sw_fetch", e_fetch(1'b1));
    tick(); push("rst_sw_decode", e_decode(2'b10));
    tick(); push("rst_sw_memadr", e_memadr(2'b01));
    tick(); RESET = 1'b0; push("rst_sw_memwrite", ex(S_MEMWRITE, 4'b0000, 1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 3'b010, 0));
    tick(); RESET = 1'b1; push("rst_sw_refetch", e_fetch(1'b1));
    tick(); push("rst_sw_decode2", e_decode(2'b10));

    tick();
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CLK);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
